// File: rtl/rof_pkg.sv
// Shared types and sizing helpers for the weighted rank filter.
package rof_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Width that holds the sum of n weights of wb bits each without overflow.
    function automatic int sum_bits(input int n, input int wb);
        return $clog2(n * ((1 << wb) - 1) + 1);
    endfunction

endpackage

// File: rtl/masked_weight_sum.sv
// Combinational sum of the weights whose mask bit is set.
module masked_weight_sum #(
    parameter int N           = 9,
    parameter int WEIGHT_BITS = 4,
    parameter int SUM_BITS    = 8
) (
    input  logic [N-1:0][WEIGHT_BITS-1:0] weights,
    input  logic [N-1:0]                  mask,
    output logic [SUM_BITS-1:0]           sum
);

    // Accumulate enabled weights; synthesis is free to rebalance the chain.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                sum = sum + SUM_BITS'(weights[i]);
            end else begin
                sum = sum;
            end
        end
    end

endmodule

// File: rtl/weighted_rank_filter.sv
// Sliding-window weighted order-statistic filter; the selected sample is
// found MSB-first by a bit-serial radix search over the window.
module weighted_rank_filter
    import rof_pkg::*;
#(
    parameter int N           = 9,
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 4,
    parameter int SUM_BITS    = sum_bits(N, WEIGHT_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [$clog2(N)-1:0]   cfg_idx,
    input  logic [WEIGHT_BITS-1:0] cfg_weight,
    input  logic [SUM_BITS-1:0]    rank,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_BITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   out_clamped,
    output logic                   busy
);

    localparam int IDX_BITS = $clog2(N);
    localparam int CNT_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_e                         state_r, state_nx_s;
    logic [N-1:0][DATA_BITS-1:0]    window_r;
    logic [N-1:0][WEIGHT_BITS-1:0]  weight_r;
    logic [N-1:0][WEIGHT_BITS-1:0]  snap_r;
    logic [N-1:0]                   mask_r;
    logic [N-1:0]                   all_mask_s;
    logic [N-1:0]                   ones_mask_s;
    logic [N-1:0]                   bit_plane_s;
    logic [N-1:0]                   c0_mask_s;
    logic [SUM_BITS-1:0]            total_s;
    logic [SUM_BITS-1:0]            c0_s;
    logic [SUM_BITS-1:0]            r_r;
    logic [SUM_BITS-1:0]            r_load_s;
    logic [CNT_BITS-1:0]            bit_r;
    logic [DATA_BITS-1:0]           result_r;
    logic [DATA_BITS-1:0]           result_nx_s;
    logic                           bit_one_s;
    logic                           clamp_r;
    logic                           zero_r;
    logic                           accept_s;
    logic                           out_hs_s;
    logic                           last_bit_s;

    logic                           in_ready_r;
    logic                           busy_r;
    logic                           out_valid_r;
    logic [DATA_BITS-1:0]           out_data_r;
    logic                           out_clamped_r;

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_clamped = out_clamped_r;

    assign accept_s   = in_valid && (state_r == IDLE);
    assign out_hs_s   = out_valid_r && out_ready;
    assign last_bit_s = (state_r == SELECT) && (bit_r == '0);

    // Per-position views: nonzero weight, current data bit, bit-0 candidates.
    always_comb begin
        ones_mask_s = '1;
        all_mask_s  = '0;
        bit_plane_s = '0;
        for (int i = 0; i < N; i++) begin
            all_mask_s[i]  = (weight_r[i] != '0);
            bit_plane_s[i] = window_r[i][bit_r];
        end
        c0_mask_s = mask_r & ~bit_plane_s;
    end

    // T is taken from the live weights because they become the snapshot on accept.
    masked_weight_sum #(
        .N          (N),
        .WEIGHT_BITS(WEIGHT_BITS),
        .SUM_BITS   (SUM_BITS)
    ) u_total_sum (
        .weights(weight_r),
        .mask   (ones_mask_s),
        .sum    (total_s)
    );

    masked_weight_sum #(
        .N          (N),
        .WEIGHT_BITS(WEIGHT_BITS),
        .SUM_BITS   (SUM_BITS)
    ) u_c0_sum (
        .weights(snap_r),
        .mask   (c0_mask_s),
        .sum    (c0_s)
    );

    // Rank clamping and the per-bit decision of the radix search.
    always_comb begin
        if (total_s == '0) begin
            r_load_s = '0;
        end else if (rank >= total_s) begin
            r_load_s = total_s - SUM_BITS'(1);
        end else begin
            r_load_s = rank;
        end
        bit_one_s           = (r_r >= c0_s);
        result_nx_s         = result_r;
        result_nx_s[bit_r]  = bit_one_s;
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = SELECT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SELECT: begin
                if (bit_r == '0) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SELECT;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Weight registers; writes land in any state, indices past the window are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                weight_r[i] <= WEIGHT_BITS'(1);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cfg_we && (cfg_idx == IDX_BITS'(i))) begin
                    weight_r[i] <= cfg_weight;
                end
            end
        end
    end

    // Window shift and radix-search state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_r <= '0;
            snap_r   <= '0;
            mask_r   <= '0;
            r_r      <= '0;
            bit_r    <= '0;
            result_r <= '0;
            clamp_r  <= 1'b0;
            zero_r   <= 1'b0;
        end else if (accept_s) begin
            window_r <= {window_r[N-2:0], in_data};
            snap_r   <= weight_r;
            mask_r   <= all_mask_s;
            r_r      <= r_load_s;
            bit_r    <= CNT_BITS'(DATA_BITS - 1);
            result_r <= '0;
            clamp_r  <= (rank >= total_s);
            zero_r   <= (total_s == '0);
        end else if (state_r == SELECT) begin
            result_r <= result_nx_s;
            bit_r    <= bit_r - CNT_BITS'(1);
            if (bit_one_s) begin
                r_r    <= r_r - c0_s;
                mask_r <= mask_r & bit_plane_s;
            end else begin
                mask_r <= mask_r & ~bit_plane_s;
            end
        end
    end

    // Output stage: result loads as DONE is entered, valid follows one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_clamped_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            busy_r      <= (state_nx_s != IDLE);
            out_valid_r <= (state_r == DONE) && !out_hs_s;
            if (last_bit_s) begin
                out_data_r    <= zero_r ? '0 : result_nx_s;
                out_clamped_r <= clamp_r || zero_r;
            end
        end
    end

endmodule
